// File: rtl/ac_op_sequencer.sv
// rtl/ac_op_sequencer.sv - accumulator operation sequencer (optional op_count via ACSEQ_OPCNT_EN)
module ac_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_addr,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_rvalid,
  output logic [7:0] dr,
  output logic       alu_and,
  output logic       alu_add,
  output logic       alu_lda,
  output logic       alu_cma,
  output logic       alu_cir,
  output logic       alu_cil,
  input  logic [7:0] alu_acdata,
  input  logic       alu_e,
  output logic [7:0] ac,
  output logic       e,
  output logic       done,
`ifdef ACSEQ_OPCNT_EN
  output logic [15:0] op_count,
`endif
  output logic       err
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_CIR = 3'd4;
  localparam logic [2:0] OP_CIL = 3'd5;
  localparam logic [2:0] OP_CLA = 3'd6;
  localparam logic [2:0] OP_CLE = 3'd7;

  localparam logic [3:0] TMO_LAST = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [7:0]  dr_q, dr_d;
  logic [7:0]  ac_q, ac_d;
  logic        e_q, e_d;
  logic [5:0]  alu_q, alu_d;    // {and, add, lda, cma, cir, cil}
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [3:0]  tmo_q, tmo_d;

  // One-hot ALU control for an opcode; CLA/CLE need no ALU and select nothing
  function automatic logic [5:0] alu_sel(input logic [2:0] op);
    if (op > OP_CIL) begin
      return 6'b000000;
    end
    return 6'b100000 >> op;
  endfunction

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    dr_d       = dr_q;
    ac_d       = ac_q;
    e_d        = e_q;
    tmo_d      = tmo_q;
    alu_d      = 6'b000000;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          mem_addr_d = req_addr;
          if (req_op <= OP_LDA) begin
            state_d  = S_FETCH;
            mem_rd_d = 1'b1;
            tmo_d    = 4'd0;
          end else begin
            state_d = S_EXEC;
            alu_d   = alu_sel(req_op);
          end
        end
      end

      S_FETCH: begin
        if (mem_rvalid) begin
          dr_d     = mem_rdata;
          mem_rd_d = 1'b0;
          state_d  = S_EXEC;
          alu_d    = alu_sel(op_q);
        end else if (tmo_q == TMO_LAST) begin
          // Memory never answered: abandon the op without touching ac/e/dr
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          tmo_d    = 4'd0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      S_EXEC: begin
        if (op_q <= OP_CIL) begin
          ac_d = alu_acdata;
        end else if (op_q == OP_CLA) begin
          ac_d = 8'h00;
        end
        if (op_q == OP_ADD || op_q == OP_CIR || op_q == OP_CIL) begin
          e_d = alu_e;
        end else if (op_q == OP_CLE) begin
          e_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      mem_addr_q <= 8'h00;
      mem_rd_q   <= 1'b0;
      dr_q       <= 8'h00;
      ac_q       <= 8'h00;
      e_q        <= 1'b0;
      alu_q      <= 6'b000000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      dr_q       <= dr_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      alu_q      <= alu_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef ACSEQ_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Completed-op counter advances with each done pulse and sticks at all-ones
  always_comb begin
    op_count_d = op_count_q;
    if (state_q == S_EXEC && op_count_q != 16'hFFFF) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Completed-op counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= 16'h0000;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign dr        = dr_q;
  assign ac        = ac_q;
  assign e         = e_q;
  assign done      = done_q;
  assign err       = err_q;
  assign alu_and   = alu_q[5];
  assign alu_add   = alu_q[4];
  assign alu_lda   = alu_q[3];
  assign alu_cma   = alu_q[2];
  assign alu_cir   = alu_q[1];
  assign alu_cil   = alu_q[0];

endmodule

// File: tb/tb_ac_op_sequencer.sv
// tb/tb_ac_op_sequencer.sv - randomized self-checking bench for ac_op_sequencer
module tb_ac_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_rvalid;
  logic [7:0] dr;
  logic       alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil;
  logic [7:0] alu_acdata;
  logic       alu_e;
  logic [7:0] ac;
  logic       e;
  logic       done;
  logic       err;
`ifdef ACSEQ_OPCNT_EN
  logic [15:0] op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the accumulator and E flag
  logic [7:0] m_ac;
  logic       m_e;

  ac_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .dr(dr),
    .alu_and(alu_and), .alu_add(alu_add), .alu_lda(alu_lda),
    .alu_cma(alu_cma), .alu_cir(alu_cir), .alu_cil(alu_cil),
    .alu_acdata(alu_acdata), .alu_e(alu_e),
    .ac(ac), .e(e), .done(done),
`ifdef ACSEQ_OPCNT_EN
    .op_count(op_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural adder/logic unit fed by the sequencer's controls
  always_comb begin
    logic [8:0] s;
    s          = {1'b0, ac} + {1'b0, dr};
    alu_acdata = ac;
    alu_e      = e;
    if (alu_and) alu_acdata = ac & dr;
    if (alu_add) {alu_e, alu_acdata} = s;
    if (alu_lda) alu_acdata = dr;
    if (alu_cma) alu_acdata = ~ac;
    if (alu_cir) {alu_acdata, alu_e} = {e, ac};
    if (alu_cil) {alu_e, alu_acdata} = {ac, e};
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] exp_ctl(input logic [2:0] op);
    case (op)
      3'd0:    return 6'b100000;
      3'd1:    return 6'b010000;
      3'd2:    return 6'b001000;
      3'd3:    return 6'b000100;
      3'd4:    return 6'b000010;
      3'd5:    return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  // Reference semantics of each opcode on (ac, e) given the fetched operand
  task automatic model_apply(input logic [2:0] op, input logic [7:0] operand);
    int         sum;
    logic [7:0] old;
    old = m_ac;
    case (op)
      3'd0: m_ac = m_ac & operand;
      3'd1: begin
        sum  = int'(m_ac) + int'(operand);
        m_ac = 8'(sum % 256);
        m_e  = (sum > 255);
      end
      3'd2: m_ac = operand;
      3'd3: m_ac = 8'(255 - int'(m_ac));
      3'd4: begin
        m_ac = 8'(int'(old) / 2 + (m_e ? 128 : 0));
        m_e  = (old % 2) == 1;
      end
      3'd5: begin
        m_ac = 8'((int'(old) * 2) % 256 + (m_e ? 1 : 0));
        m_e  = old >= 8'd128;
      end
      3'd6: m_ac = 8'h00;
      default: m_e = 1'b0;
    endcase
  endtask

  // Issue one op and follow it cycle by cycle; dly = rvalid wait for memory ops
  task automatic run_op(input logic [2:0] op, input logic [7:0] addr,
                        input logic [7:0] rdata, input int dly);
    logic [7:0] dr_before;
    logic [5:0] ctl;
    dr_before = dr;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_op op=%0d actual=%b required=1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr;
    step;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = 8'($urandom);
    if (op <= 3'd2) begin
      n_checks++;
      if ({mem_rd, mem_addr} !== {1'b1, addr}) begin
        n_fail++; $display("FAIL fetch_strobe op=%0d actual=%b/%h required=1/%h", op, mem_rd, mem_addr, addr);
      end
      for (int i = 0; i < dly; i++) begin
        req_valid = 1'($urandom);
        step;
      end
      req_valid = 1'b0;
      n_checks++;
      if (mem_rd !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL fetch_hold op=%0d actual=%b%b required=10", op, mem_rd, req_ready);
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step;
      mem_rvalid = 1'b0; mem_rdata = 8'($urandom);
      n_checks++;
      if (dr !== rdata || mem_rd !== 1'b0) begin
        n_fail++; $display("FAIL fetch_capture op=%0d actual=%h/%b required=%h/0", op, dr, mem_rd, rdata);
      end
      model_apply(op, rdata);
    end else begin
      n_checks++;
      if (mem_rd !== 1'b0) begin
        n_fail++; $display("FAIL no_fetch op=%0d actual=%b required=0", op, mem_rd);
      end
      model_apply(op, dr_before);
      mem_rvalid = 1'b1; mem_rdata = 8'($urandom);
    end
    ctl = {alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil};
    n_checks++;
    if (ctl !== exp_ctl(op) || done !== 1'b0) begin
      n_fail++; $display("FAIL exec_ctl op=%0d actual=%b done=%b required=%b done=0", op, ctl, done, exp_ctl(op));
    end
    step;
    mem_rvalid = 1'b0;
    ctl = {alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil};
    n_checks++;
    if (done !== 1'b1 || ac !== m_ac || e !== m_e || ctl !== 6'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL done_result op=%0d actual done=%b ac=%h e=%b ctl=%b rdy=%b required done=1 ac=%h e=%b ctl=0 rdy=0",
                         op, done, ac, e, ctl, req_ready, m_ac, m_e);
    end
    if (op > 3'd2) begin
      n_checks++;
      if (dr !== dr_before) begin
        n_fail++; $display("FAIL dr_stable op=%0d actual=%h required=%h", op, dr, dr_before);
      end
    end
    step;
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_done op=%0d actual done=%b rdy=%b required done=0 rdy=1", op, done, req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom); req_op = 3'($urandom); req_addr = 8'($urandom);
      mem_rvalid = 1'($urandom); mem_rdata = 8'($urandom);
      step;
    end
    req_valid = 1'b0; mem_rvalid = 1'b0;
    rst_n = 1'b1;
    m_ac = 8'h00; m_e = 1'b0;
    n_checks++;
    if ({req_ready, mem_rd, mem_addr, dr, ac, e, done, err} !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state actual rdy=%b rd=%b addr=%h dr=%h ac=%h e=%b done=%b err=%b required 1/0/00/00/00/0/0/0",
                         req_ready, mem_rd, mem_addr, dr, ac, e, done, err);
    end
    n_checks++;
    if ({alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil} !== 6'b0) begin
      n_fail++; $display("FAIL reset_alu actual=%b required=000000", {alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil});
    end
  endtask

  task automatic test_directed;
    run_op(3'd2, 8'h20, 8'h0F, 1);     // LDA -> ac=0F
    run_op(3'd1, 8'h10, 8'hF3, 2);     // ADD -> ac=02, e=1
    n_checks++;
    if (ac !== 8'h02 || e !== 1'b1) begin
      n_fail++; $display("FAIL add_carry actual ac=%h e=%b required ac=02 e=1", ac, e);
    end
    run_op(3'd2, 8'h21, 8'hA5, 0);     // LDA -> ac=A5
    run_op(3'd3, 8'h00, 8'h00, 0);     // CMA -> ac=5A, e stays 1
    n_checks++;
    if (ac !== 8'h5A || e !== 1'b1) begin
      n_fail++; $display("FAIL cma actual ac=%h e=%b required ac=5A e=1", ac, e);
    end
    run_op(3'd2, 8'h22, 8'h01, 3);     // LDA -> ac=01
    run_op(3'd4, 8'h00, 8'h00, 0);     // CIR -> ac=80, e=1
    n_checks++;
    if (ac !== 8'h80 || e !== 1'b1) begin
      n_fail++; $display("FAIL cir actual ac=%h e=%b required ac=80 e=1", ac, e);
    end
    run_op(3'd7, 8'h00, 8'h00, 0);     // CLE -> e=0
    n_checks++;
    if (ac !== 8'h80 || e !== 1'b0) begin
      n_fail++; $display("FAIL cle actual ac=%h e=%b required ac=80 e=0", ac, e);
    end
    run_op(3'd5, 8'h00, 8'h00, 0);     // CIL -> ac=00, e=1
    run_op(3'd6, 8'h00, 8'h00, 0);     // CLA -> ac=00, e stays
  endtask

  task automatic test_timeout;
    int         cnt;
    logic [7:0] dr_before;
    dr_before = dr;
    req_valid = 1'b1; req_op = 3'd2; req_addr = 8'h44;
    step;
    req_valid = 1'b0;
    cnt = 0;
    while (mem_rd === 1'b1 && cnt < 24) begin
      cnt++;
      step;
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++; $display("FAIL timeout_len actual=%0d required=16", cnt);
    end
    n_checks++;
    if (err !== 1'b1 || req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err actual err=%b rdy=%b done=%b required 1/1/0", err, req_ready, done);
    end
    n_checks++;
    if (ac !== m_ac || e !== m_e || dr !== dr_before) begin
      n_fail++; $display("FAIL timeout_regs actual ac=%h e=%b dr=%h required ac=%h e=%b dr=%h", ac, e, dr, m_ac, m_e, dr_before);
    end
    step;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse actual=%b required=0", err);
    end
  endtask

  task automatic test_reset_mid_fetch;
    run_op(3'd2, 8'h30, 8'h77, 0);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 8'h31;
    step;
    req_valid = 1'b0;
    step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    m_ac = 8'h00; m_e = 1'b0;
    n_checks++;
    if ({req_ready, mem_rd, mem_addr, ac, e, dr} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_mid_fetch actual rdy=%b rd=%b addr=%h ac=%h e=%b dr=%h required 1/0/00/00/0/00",
                         req_ready, mem_rd, mem_addr, ac, e, dr);
    end
    mem_rvalid = 1'b1; mem_rdata = 8'hFF;
    step;
    mem_rvalid = 1'b0;
    n_checks++;
    if (dr !== 8'h00 || mem_rd !== 1'b0 || req_ready !== 1'b1 ||
        {alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil} !== 6'b0) begin
      n_fail++; $display("FAIL late_rvalid actual dr=%h rd=%b rdy=%b required dr=00 rd=0 rdy=1", dr, mem_rd, req_ready);
    end
    step;
    n_checks++;
    if (done !== 1'b0 || ac !== 8'h00) begin
      n_fail++; $display("FAIL late_rvalid_done actual done=%b ac=%h required done=0 ac=00", done, ac);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      run_op(3'(i + 2), 8'(i), 8'($urandom), 0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
    end
  endtask

`ifdef ACSEQ_OPCNT_EN
  task automatic test_op_count;
    logic [15:0] before;
    before = op_count;
    run_op(3'd3, 8'h00, 8'h00, 0);
    n_checks++;
    if (op_count !== before + 16'd1) begin
      n_fail++; $display("FAIL opcnt_inc actual=%h required=%h", op_count, before + 16'd1);
    end
    test_timeout;
    n_checks++;
    if (op_count !== before + 16'd1) begin
      n_fail++; $display("FAIL opcnt_err actual=%h required=%h", op_count, before + 16'd1);
    end
    force dut.op_count_q = 16'hFFFE;
    step;
    release dut.op_count_q;
    run_op(3'd6, 8'h00, 8'h00, 0);
    run_op(3'd2, 8'h05, 8'h12, 1);
    n_checks++;
    if (op_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL opcnt_sat actual=%h required=FFFF", op_count);
    end
    test_timeout;
    n_checks++;
    if (op_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL opcnt_sat_err actual=%h required=FFFF", op_count);
    end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00;
    mem_rvalid = 1'b0; mem_rdata = 8'h00; rst_n = 1'b0;
    m_ac = 8'h00; m_e = 1'b0;
    step;
    test_reset;
    test_directed;
    test_timeout;
    test_reset_mid_fetch;
    test_back_to_back;
    test_random;
`ifdef ACSEQ_OPCNT_EN
    test_op_count;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
